conf_reg_bank: RTL
==================

// Module: conf_reg_bank
// PURPOSE
//  Parametrised, double-buffered configuration register bank for the flexML accelerator.
//  - Host writes land in a shadow bank, with byte enables and 1-cycle read-back.
//  - The datapath sees only the active bank.
//  - On commit_req (frame/layer boundary pulse from the controller), shadow is copied to active.
//    Reprogramming for frame N+1 therefore never disturbs frame N.
// PARAMETERS
//  N_REGS   16  number of 32-bit-class registers (>=2)
//  DATA_W   32  register width; multiple of 8
//  ADDR_W   32  host address width; address = word index, no byte offset
// PORTS
//  clk            in   1                clock
//  reset          in   1                asynchronous, active-low reset
//  wr_en_ext      in   1                host write strobe, single cycle per write
//  wr_addr_ext    in   ADDR_W           write word index
//  wr_data_ext    in   DATA_W           write data
//  wr_be_ext      in   DATA_W/8         byte enables; bit k gates byte k
//  rd_en_ext      in   1                host read strobe
//  rd_addr_ext    in   ADDR_W           read word index
//  rd_data_ext    out  DATA_W           shadow read data
//  rd_valid_ext   out  1                one-cycle pulse, 1 cycle after rd_en_ext
//  commit_req     in   1                pulse: copy shadow -> active
//  clr_err        in   1                clears addr_err (and par_err when enabled)
//  conf_active    out  N_REGS*DATA_W    active bank, reg i at [i*DATA_W +: DATA_W]
//  dirty          out  1                shadow differs in history from active (write since last commit)
//  commit_cnt     out  16               number of commits, wraps 0xFFFF->0
//  addr_err       out  1                sticky out-of-range access flag
//  par_err        out  1                sticky parity error (0 when feature off)
// BEHAVIOUR
//  - Reset: shadow, active, rd_data_ext, rd_valid_ext, dirty, commit_cnt, addr_err and par_err
//    are all 0, asynchronously.
//  - Write, in range (addr < N_REGS): shadow[addr] byte k <= wr_data byte k where wr_be[k]=1;
//    dirty <= 1, including when wr_be=0.
//  - Write, out of range: no shadow change; addr_err <= 1; dirty unchanged.
//  - Read: rd_en in cycle t -> rd_valid=1 and rd_data=shadow[addr] in cycle t+1.
//    - Value is sampled before any same-cycle write (read-old).
//    - Out-of-range read returns 0, still pulses rd_valid, sets addr_err.
//    - rd_data holds its last value while rd_valid=0.
//  - Commit: commit_req in cycle t -> active <= shadow (pre-write value of cycle t) at edge t+1;
//    commit_cnt += 1.
//    - dirty <= 0, unless an in-range write is accepted in the same cycle: then dirty stays 1
//      and that write waits for the next commit.
//  - Commits are back-to-back legal, one per cycle; each increments commit_cnt.
//  - clr_err and a new error in the same cycle: the error wins (flag stays 1).
//  - Reads and writes may coincide in any combination with each other and with commit.
//  - No stall or backpressure: every strobe is accepted in its cycle.
//  - Address compare uses the full ADDR_W; upper bits nonzero = out of range.
//  - Reset asserted mid-operation discards shadow and active: no partial commit, no pending read.
// CONFIGURATION
//  CONF_PARITY_EN defined:
//    - Even parity bit per active register, computed from shadow at commit.
//    - Every active register is re-checked each cycle; any mismatch sets par_err (sticky).
//    - clr_err clears par_err.
//  CONF_PARITY_EN undefined:
//    - No parity storage; par_err tied to 0.
// STRUCTURE
//  - Package parameters: CONF_N_REGS, CONF_DATA_W and the register index constants
//    (CONF_IDX_MEM_PTR_FC=0, CONF_IDX_FIRST_FC_LOG=1, CONF_IDX_FRAME_BY_FRAME=2).
//  - Sub-module conf_reg_word: one shadow+active word pair.
//    - Inputs: byte-enabled write, commit load and optional parity.
//    - Instantiated N_REGS times in a generate loop.
//  - Top level holds address decode, read mux, dirty/err/commit_cnt logic.
// TESTING
//  1 reset, then write 0xDEADBEEF to reg 2, be=0xF -> conf_active[2] stays 0 and dirty=1;
//    commit_req -> conf_active[2]=0xDEADBEEF, dirty=0, commit_cnt=1.
//  2 reg 0 holds 0x11223344; write 0xAABBCCDD be=0b0101 -> read-back 0x11BB33DD, 1 cycle later
//    with rd_valid=1.
//  3 write reg 1 =5 in the same cycle as commit_req (reg 1 shadow was 3) -> active[1]=3, dirty=1;
//    next commit -> active[1]=5, dirty=0.
//  4 write to addr N_REGS (16) and read addr 0x80000001 -> no state change, read returns 0,
//    addr_err=1 sticky; clr_err -> 0; clr_err + bad write in the same cycle -> addr_err stays 1.
//  5 preload commit_cnt to 0xFFFF via 65535 commits; one more commit -> 0;
//    assert reset mid-burst -> all outputs 0.
//  6 (CONF_PARITY_EN) commit 0x1, force-flip active[0] bit 4 -> par_err=1 next cycle;
//    without the macro par_err stays 0.

Source files
------------

// File: rtl/conf_reg_bank_pkg.sv
// conf_reg_bank_pkg: shared sizing constants and register index map for the
// flexML configuration register bank.
package conf_reg_bank_pkg;

  localparam int CONF_N_REGS = 16;
  localparam int CONF_DATA_W = 32;
  localparam int CONF_ADDR_W = 32;
  localparam int CONF_CNT_W  = 16;

  // Register index map used by the datapath
  localparam int CONF_IDX_MEM_PTR_FC     = 0;
  localparam int CONF_IDX_FIRST_FC_LOG   = 1;
  localparam int CONF_IDX_FRAME_BY_FRAME = 2;

endpackage

// File: rtl/conf_reg_word.sv
// conf_reg_word: one shadow/active register pair.
//   clk, reset  : clock, asynchronous active-low reset
//   wr_en       : byte-enabled write into the shadow word
//   wr_data     : write data
//   wr_be       : byte enables, bit k gates byte k
//   commit      : load active <= shadow (value before any same-cycle write)
//   shadow      : current shadow contents
//   active      : current active contents
//   par_bad     : (CONF_PARITY_EN only) active word disagrees with its stored parity
// Optional feature macro: CONF_PARITY_EN
module conf_reg_word
  import conf_reg_bank_pkg::*;
#(
  parameter int DATA_W = CONF_DATA_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic                commit,
  output logic [DATA_W-1:0]   shadow,
  output logic [DATA_W-1:0]   active
`ifdef CONF_PARITY_EN
  ,
  output logic                par_bad
`endif
);

  logic [DATA_W-1:0] merged;

  always_comb begin
    merged = shadow;
    for (int unsigned k = 0; k < DATA_W/8; k++) begin
      if (wr_be[k]) merged[k*8 +: 8] = wr_data[k*8 +: 8];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow <= '0;
      active <= '0;
    end else begin
      if (wr_en)  shadow <= merged;
      if (commit) active <= shadow;
    end
  end

`ifdef CONF_PARITY_EN
  // Even parity: stored bit makes the total count of ones in {active, par_bit} even.
  logic par_bit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      par_bit <= 1'b0;
    else if (commit) par_bit <= ^shadow;
  end

  assign par_bad = (^active) ^ par_bit;
`endif

endmodule

// File: rtl/conf_reg_bank.sv
// conf_reg_bank: double-buffered configuration register bank.
// Host writes land in the shadow bank; commit_req copies shadow to the active
// bank seen by the datapath.
//   clk, reset    : clock, asynchronous active-low reset
//   wr_*_ext      : host write strobe / word index / data / byte enables
//   rd_*_ext      : host read strobe / word index, read data and valid (1 cycle later)
//   commit_req    : copy shadow -> active
//   clr_err       : clear sticky error flags
//   conf_active   : active bank, reg i at [i*DATA_W +: DATA_W]
//   dirty         : an in-range write happened since the last commit
//   commit_cnt    : commit counter, wraps
//   addr_err      : sticky out-of-range access flag
//   par_err       : sticky parity error (tied 0 unless CONF_PARITY_EN)
// Optional feature macro: CONF_PARITY_EN
module conf_reg_bank
  import conf_reg_bank_pkg::*;
#(
  parameter int N_REGS = CONF_N_REGS,
  parameter int DATA_W = CONF_DATA_W,
  parameter int ADDR_W = CONF_ADDR_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en_ext,
  input  logic [ADDR_W-1:0]        wr_addr_ext,
  input  logic [DATA_W-1:0]        wr_data_ext,
  input  logic [DATA_W/8-1:0]      wr_be_ext,
  input  logic                     rd_en_ext,
  input  logic [ADDR_W-1:0]        rd_addr_ext,
  output logic [DATA_W-1:0]        rd_data_ext,
  output logic                     rd_valid_ext,
  input  logic                     commit_req,
  input  logic                     clr_err,
  output logic [N_REGS*DATA_W-1:0] conf_active,
  output logic                     dirty,
  output logic [CONF_CNT_W-1:0]    commit_cnt,
  output logic                     addr_err,
  output logic                     par_err
);

  logic [DATA_W-1:0] shadow [N_REGS];
  logic [DATA_W-1:0] active [N_REGS];
  logic [DATA_W-1:0] rd_mux;
  logic              wr_hit;
  logic              rd_hit;
  logic              new_err;

  // Full-width compare: any nonzero upper bit is out of range.
  assign wr_hit  = wr_addr_ext < ADDR_W'(N_REGS);
  assign rd_hit  = rd_addr_ext < ADDR_W'(N_REGS);
  assign new_err = (wr_en_ext && !wr_hit) || (rd_en_ext && !rd_hit);

`ifdef CONF_PARITY_EN
  logic [N_REGS-1:0] par_bad;
`endif

  for (genvar i = 0; i < N_REGS; i++) begin : g_word
    conf_reg_word #(
      .DATA_W(DATA_W)
    ) u_word (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en_ext && (wr_addr_ext == ADDR_W'(i))),
      .wr_data (wr_data_ext),
      .wr_be   (wr_be_ext),
      .commit  (commit_req),
      .shadow  (shadow[i]),
      .active  (active[i])
`ifdef CONF_PARITY_EN
      ,
      .par_bad (par_bad[i])
`endif
    );
    assign conf_active[i*DATA_W +: DATA_W] = active[i];
  end

  // Out-of-range reads fall through to zero.
  always_comb begin
    rd_mux = '0;
    for (int unsigned i = 0; i < N_REGS; i++) begin
      if (rd_addr_ext == ADDR_W'(i)) rd_mux = shadow[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_ext  <= '0;
      rd_valid_ext <= 1'b0;
    end else begin
      rd_valid_ext <= rd_en_ext;
      if (rd_en_ext) rd_data_ext <= rd_mux;
    end
  end

  // A write accepted alongside a commit belongs to the next frame, so dirty stays set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dirty      <= 1'b0;
      commit_cnt <= '0;
    end else begin
      if (wr_en_ext && wr_hit) dirty <= 1'b1;
      else if (commit_req)     dirty <= 1'b0;
      if (commit_req) commit_cnt <= commit_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       addr_err <= 1'b0;
    else if (new_err) addr_err <= 1'b1;
    else if (clr_err) addr_err <= 1'b0;
  end

`ifdef CONF_PARITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         par_err <= 1'b0;
    else if (|par_bad)  par_err <= 1'b1;
    else if (clr_err)   par_err <= 1'b0;
  end
`else
  assign par_err = 1'b0;
`endif

endmodule
